// File: rtl/mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access
//  Purpose  : Memory-access stage of the 5-stage pipeline. Sits between the
//             ex_mem and mem_wb pipeline registers. Loads/stores become
//             req/ack transactions on the data-memory port. Load data is
//             lane-aligned and sign/zero-extended. The pipeline is stalled
//             while a transaction is outstanding.
//  Ports    :
//    clk, rst (async, active-low)
//    flush_i, downstream_stall_i            : pipeline control
//    pc_i, inst_data_i, rd_addr_i           : pass-through to mem_wb
//    alu_data_i, store_data_i               : address / store operand
//    load_valid_i, store_valid_i,
//    mem_size_i, mem_unsigned_i             : operation decode
//    mem_req_o, mem_we_o, mem_addr_o,
//    mem_wdata_o, mem_wstrb_o,
//    mem_ack_i, mem_rdata_i                 : data-memory port
//    stall_req_o, misalign_o,
//    misalign_store_o                       : to controller / trap unit
//    pc_o, inst_data_o, rd_addr_o,
//    mem_data_o                             : to mem_wb
//  Revision : 1.0 - initial release
// ============================================================================
module mem_access #(
   parameter int XLEN          = 64,
   parameter int REG_ADDRWIDTH = 5
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush_i,
   input  logic                     downstream_stall_i,
   input  logic [XLEN-1:0]          pc_i,
   input  logic [31:0]              inst_data_i,
   input  logic [REG_ADDRWIDTH-1:0] rd_addr_i,
   input  logic [XLEN-1:0]          alu_data_i,
   input  logic [XLEN-1:0]          store_data_i,
   input  logic                     load_valid_i,
   input  logic                     store_valid_i,
   input  logic [1:0]               mem_size_i,
   input  logic                     mem_unsigned_i,
   output logic                     mem_req_o,
   output logic                     mem_we_o,
   output logic [XLEN-1:0]          mem_addr_o,
   output logic [XLEN-1:0]          mem_wdata_o,
   output logic [7:0]               mem_wstrb_o,
   input  logic                     mem_ack_i,
   input  logic [XLEN-1:0]          mem_rdata_i,
   output logic                     stall_req_o,
   output logic                     misalign_o,
   output logic                     misalign_store_o,
   output logic [XLEN-1:0]          pc_o,
   output logic [31:0]              inst_data_o,
   output logic [REG_ADDRWIDTH-1:0] rd_addr_o,
   output logic [XLEN-1:0]          mem_data_o
);

   localparam logic [31:0] c_NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_WAIT  = 2'd1,
      S_DONE  = 2'd2,
      S_DRAIN = 2'd3
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nx;
   logic                     r_req;
   logic                     r_we;
   logic [XLEN-1:0]          r_addr;     // full effective address; low bits give lane offset
   logic [XLEN-1:0]          r_wdata;
   logic [7:0]               r_wstrb;
   logic [1:0]               r_size;
   logic                     r_uns;
   logic [XLEN-1:0]          r_pc;
   logic [31:0]              r_inst;
   logic [REG_ADDRWIDTH-1:0] r_rd;
   logic [XLEN-1:0]          r_data;

   logic                     w_mem_op;
   logic                     w_misaligned;
   logic                     w_issue;
   logic [7:0]               w_strb_base;
   logic [XLEN-1:0]          w_raw;
   logic [XLEN-1:0]          w_ld_fmt;

   assign w_mem_op = load_valid_i | store_valid_i;

   // Operand decode for a new access
   always_comb begin
      w_misaligned = 1'b0;
      w_strb_base  = 8'h01;
      case (mem_size_i)
         2'd0: begin w_misaligned = 1'b0;                       w_strb_base = 8'h01; end
         2'd1: begin w_misaligned = alu_data_i[0];              w_strb_base = 8'h03; end
         2'd2: begin w_misaligned = (alu_data_i[1:0] != 2'b00); w_strb_base = 8'h0F; end
         default: begin w_misaligned = (alu_data_i[2:0] != 3'b000); w_strb_base = 8'hFF; end
      endcase
   end

   // Load formatting uses the registered offset/size, since ex_mem may
   // already hold a different instruction by the time the ack arrives.
   always_comb begin
      w_raw    = mem_rdata_i >> {r_addr[2:0], 3'b000};
      w_ld_fmt = w_raw;
      case (r_size)
         2'd0: w_ld_fmt = {{(XLEN-8){~r_uns & w_raw[7]}},   w_raw[7:0]};
         2'd1: w_ld_fmt = {{(XLEN-16){~r_uns & w_raw[15]}}, w_raw[15:0]};
         2'd2: w_ld_fmt = {{(XLEN-32){~r_uns & w_raw[31]}}, w_raw[31:0]};
         default: w_ld_fmt = w_raw;
      endcase
   end

   // Next state and stage outputs
   always_comb begin
      w_state_nx       = r_state;
      w_issue          = 1'b0;
      stall_req_o      = 1'b0;
      misalign_o       = 1'b0;
      misalign_store_o = 1'b0;
      pc_o             = pc_i;
      inst_data_o      = inst_data_i;
      rd_addr_o        = flush_i ? '0 : rd_addr_i;
      mem_data_o       = alu_data_i;
      case (r_state)
         S_IDLE: begin
            if (w_mem_op) begin
               if (w_misaligned) begin
                  misalign_o       = 1'b1;
                  misalign_store_o = store_valid_i;
               end else if (!flush_i) begin
                  stall_req_o = 1'b1;
                  w_issue     = 1'b1;
                  w_state_nx  = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            // Bubble towards mem_wb until the result is captured
            rd_addr_o = '0;
            if (flush_i) begin
               w_state_nx = mem_ack_i ? S_IDLE : S_DRAIN;
            end else begin
               stall_req_o = 1'b1;
               if (mem_ack_i) begin
                  w_state_nx = S_DONE;
               end
            end
         end
         S_DONE: begin
            pc_o        = r_pc;
            inst_data_o = r_inst;
            rd_addr_o   = flush_i ? '0 : r_rd;
            mem_data_o  = r_data;
            if (flush_i || !downstream_stall_i) begin
               w_state_nx = S_IDLE;
            end
         end
         default: begin
            // DRAIN: the flushed request is still on the bus. Non-memory
            // work passes straight through; a new memory op must wait.
            if (w_mem_op) begin
               stall_req_o = 1'b1;
               rd_addr_o   = '0;
            end
            if (mem_ack_i) begin
               w_state_nx = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_req   <= 1'b0;
         r_we    <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wstrb <= '0;
         r_size  <= '0;
         r_uns   <= 1'b0;
         r_pc    <= '0;
         r_inst  <= c_NOP;
         r_rd    <= '0;
         r_data  <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_issue) begin
            r_req   <= 1'b1;
            r_we    <= store_valid_i;
            r_addr  <= alu_data_i;
            r_wdata <= store_data_i << {alu_data_i[2:0], 3'b000};
            r_wstrb <= w_strb_base << alu_data_i[2:0];
            r_size  <= mem_size_i;
            r_uns   <= mem_unsigned_i;
            r_pc    <= pc_i;
            r_inst  <= inst_data_i;
            r_rd    <= rd_addr_i;
         end else if (r_req && mem_ack_i) begin
            r_req <= 1'b0;
         end
         if ((r_state == S_WAIT) && mem_ack_i && !flush_i) begin
            r_data <= r_we ? r_addr : w_ld_fmt;
         end
      end
   end

   assign mem_req_o   = r_req;
   assign mem_we_o    = r_we;
   assign mem_addr_o  = {r_addr[XLEN-1:3], 3'b000};
   assign mem_wdata_o = r_wdata;
   assign mem_wstrb_o = r_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_access.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_mem_access
//  Purpose  : Directed, self-checking bench for mem_access.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush_i, downstream_stall_i;
   logic [63:0] pc_i;
   logic [31:0] inst_data_i;
   logic [4:0]  rd_addr_i;
   logic [63:0] alu_data_i, store_data_i;
   logic        load_valid_i, store_valid_i;
   logic [1:0]  mem_size_i;
   logic        mem_unsigned_i;
   logic        mem_req_o, mem_we_o;
   logic [63:0] mem_addr_o, mem_wdata_o;
   logic [7:0]  mem_wstrb_o;
   logic        mem_ack_i;
   logic [63:0] mem_rdata_i;
   logic        stall_req_o, misalign_o, misalign_store_o;
   logic [63:0] pc_o;
   logic [31:0] inst_data_o;
   logic [4:0]  rd_addr_o;
   logic [63:0] mem_data_o;

   always #5 clk = ~clk;

   mem_access #(.XLEN(64), .REG_ADDRWIDTH(5)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i), .downstream_stall_i(downstream_stall_i),
      .pc_i(pc_i), .inst_data_i(inst_data_i), .rd_addr_i(rd_addr_i),
      .alu_data_i(alu_data_i), .store_data_i(store_data_i),
      .load_valid_i(load_valid_i), .store_valid_i(store_valid_i),
      .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
      .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
      .stall_req_o(stall_req_o), .misalign_o(misalign_o), .misalign_store_o(misalign_store_o),
      .pc_o(pc_o), .inst_data_o(inst_data_o), .rd_addr_o(rd_addr_o), .mem_data_o(mem_data_o)
   );

   int n_checks = 0;
   int n_err    = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   function automatic int nbytes(input logic [1:0] sz);
      return 1 << sz;
   endfunction

   function automatic logic mis_model(input logic [1:0] sz, input logic [63:0] addr);
      return (int'(addr[2:0]) % nbytes(sz)) != 0;
   endfunction

   function automatic logic [63:0] ld_model(input logic [1:0] sz, input logic uns,
                                            input logic [63:0] addr, input logic [63:0] rdata);
      logic [63:0] v;
      int nb;
      int off;
      v   = '0;
      nb  = nbytes(sz);
      off = int'(addr[2:0]);
      for (int i = 0; i < nb; i++) v[i*8 +: 8] = rdata[(off+i)*8 +: 8];
      if (!uns && v[nb*8-1]) for (int i = nb; i < 8; i++) v[i*8 +: 8] = 8'hFF;
      return v;
   endfunction

   function automatic logic [7:0] strb_model(input logic [1:0] sz, input logic [63:0] addr);
      logic [7:0] s;
      s = '0;
      for (int i = 0; i < nbytes(sz); i++) s[int'(addr[2:0]) + i] = 1'b1;
      return s;
   endfunction

   // ---------------- expectations for the compare process ----------------
   logic        ck_on = 1'b0;
   logic        e_stall = 1'b0, e_req = 1'b0, e_mis = 1'b0;
   logic        ck_rd = 1'b0, ck_data = 1'b0, ck_pc = 1'b0, ck_bus = 1'b0, ck_wr = 1'b0;
   logic [4:0]  e_rd = '0;
   logic [63:0] e_data = '0, e_pc = '0, e_addr = '0, e_wdata = '0;
   logic [31:0] e_inst = '0;
   logic        e_we = 1'b0;
   logic [7:0]  e_wstrb = '0;

   always @(negedge clk) begin
      if (ck_on) begin
         check("stall_req", 64'(stall_req_o), 64'(e_stall));
         check("mem_req", 64'(mem_req_o), 64'(e_req));
         check("misalign", 64'(misalign_o), 64'(e_mis));
         if (ck_rd)   check("rd_addr", 64'(rd_addr_o), 64'(e_rd));
         if (ck_data) check("mem_data", mem_data_o, e_data);
         if (ck_pc) begin
            check("pc", pc_o, e_pc);
            check("inst", 64'(inst_data_o), 64'(e_inst));
         end
         if (ck_bus) begin
            check("mem_we", 64'(mem_we_o), 64'(e_we));
            check("mem_addr", mem_addr_o, e_addr);
         end
         if (ck_wr) begin
            check("mem_wdata", mem_wdata_o, e_wdata);
            check("mem_wstrb", 64'(mem_wstrb_o), 64'(e_wstrb));
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_exp(input logic st, input logic rq, input logic rd_on, input logic dat_on,
                          input logic pc_on, input logic bus_on, input logic wr_on);
      e_stall = st; e_req = rq; e_mis = 1'b0;
      ck_rd = rd_on; ck_data = dat_on; ck_pc = pc_on; ck_bus = bus_on; ck_wr = wr_on;
   endtask

   // One IDLE cycle with a non-memory instruction
   task automatic idle_cycle(input logic [63:0] alu, input logic [4:0] rd, input logic fl);
      step();
      load_valid_i = 1'b0; store_valid_i = 1'b0; flush_i = fl; mem_ack_i = 1'b0;
      downstream_stall_i = 1'b0; alu_data_i = alu; rd_addr_i = rd;
      pc_i = alu + 64'h100; inst_data_i = 32'h00A0_0093;
      set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      e_rd = fl ? 5'd0 : rd; e_data = alu; e_pc = alu + 64'h100; e_inst = 32'h00A0_0093;
      ck_on = 1'b1;
   endtask

   // Complete aligned load/store: op at T0, ack n cycles after req, ds cycles
   // of downstream stall in DONE, then one IDLE cycle.
   task automatic mem_txn(input logic ld, input logic [1:0] sz, input logic uns,
                          input logic [63:0] addr, input logic [63:0] sdata,
                          input logic [63:0] rdata, input int n, input int ds,
                          input logic [4:0] rd, output int stall_cnt,
                          output logic [63:0] result, output logic [63:0] bus_addr,
                          output logic [63:0] bus_wdata, output logic [7:0] bus_wstrb);
      logic [63:0] exp_res;
      exp_res   = ld ? ld_model(sz, uns, addr, rdata) : addr;
      stall_cnt = 0;
      step();
      load_valid_i = ld; store_valid_i = !ld; mem_size_i = sz; mem_unsigned_i = uns;
      alu_data_i = addr; store_data_i = sdata; rd_addr_i = ld ? rd : 5'd0;
      pc_i = addr ^ 64'h4000_0000; inst_data_i = ld ? 32'h0000_3003 : 32'h0000_3023;
      flush_i = 1'b0; downstream_stall_i = 1'b0; mem_ack_i = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2; if (stall_req_o) stall_cnt++;
      for (int k = 0; k <= n; k++) begin
         step();
         mem_ack_i   = (k == n);
         mem_rdata_i = (k == n) ? rdata : 64'hDEAD_BEEF_DEAD_BEEF;
         set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, !ld);
         e_we = !ld; e_addr = {addr[63:3], 3'b000};
         e_wdata = sdata << (8 * int'(addr[2:0])); e_wstrb = strb_model(sz, addr);
         #2; if (stall_req_o) stall_cnt++;
         bus_addr = mem_addr_o; bus_wdata = mem_wdata_o; bus_wstrb = mem_wstrb_o;
      end
      for (int k = 0; k <= ds; k++) begin
         step();
         mem_ack_i = 1'b0; mem_rdata_i = 64'h0BAD_0BAD_0BAD_0BAD;
         downstream_stall_i = (k < ds);
         set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
         e_rd = ld ? rd : 5'd0; e_data = exp_res;
         e_pc = addr ^ 64'h4000_0000; e_inst = ld ? 32'h0000_3003 : 32'h0000_3023;
         #2; if (stall_req_o) stall_cnt++;
         result = mem_data_o;
      end
      idle_cycle(64'h0000_0000_0000_5A5A, 5'd3, 1'b0);
   endtask

   task automatic mis_cycle(input logic ld, input logic [1:0] sz, input logic [63:0] addr);
      step();
      load_valid_i = ld; store_valid_i = !ld; mem_size_i = sz; mem_unsigned_i = 1'b0;
      alu_data_i = addr; rd_addr_i = ld ? 5'd7 : 5'd0; flush_i = 1'b0; mem_ack_i = 1'b0;
      set_exp(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
      e_mis = mis_model(sz, addr); e_data = addr;
      #2; check("misalign_store", 64'(misalign_store_o), 64'(!ld));
   endtask

   // ---------------- main sequence ----------------
   int          sc;
   logic [63:0] res, ba, bw;
   logic [7:0]  bs;

   initial begin
      rst = 1'b0; flush_i = 1'b0; downstream_stall_i = 1'b0; pc_i = '0; inst_data_i = '0;
      rd_addr_i = '0; alu_data_i = '0; store_data_i = '0; load_valid_i = 1'b0;
      store_valid_i = 1'b0; mem_size_i = '0; mem_unsigned_i = 1'b0; mem_ack_i = 1'b0;
      mem_rdata_i = '0;
      #1;
      check("rst mem_req", 64'(mem_req_o), 64'h0);
      check("rst mem_we", 64'(mem_we_o), 64'h0);
      check("rst mem_addr", mem_addr_o, 64'h0);
      check("rst mem_wdata", mem_wdata_o, 64'h0);
      check("rst mem_wstrb", 64'(mem_wstrb_o), 64'h0);
      check("rst stall", 64'(stall_req_o), 64'h0);
      step(); step();
      rst = 1'b1;

      // ALU pass-through, 0-cycle latency, then a flushed one
      idle_cycle(64'h1234, 5'd5, 1'b0);
      #2;
      check("alu data", mem_data_o, 64'h1234);
      check("alu rd", 64'(rd_addr_o), 64'd5);
      idle_cycle(64'h9999, 5'd6, 1'b1);

      // LB / LBU at 0x8000_0003, ack 2 cycles after req
      mem_txn(1'b1, 2'd0, 1'b0, 64'h8000_0003, 64'h0, 64'h0000_0000_8100_0000, 2, 0, 5'd10,
              sc, res, ba, bw, bs);
      check("LB result", res, 64'hFFFF_FFFF_FFFF_FF81);
      check("LB addr", ba, 64'h8000_0000);
      check("LB stall cycles", 64'(sc), 64'd4);
      mem_txn(1'b1, 2'd0, 1'b1, 64'h8000_0003, 64'h0, 64'h0000_0000_8100_0000, 2, 0, 5'd10,
              sc, res, ba, bw, bs);
      check("LBU result", res, 64'h81);

      // SH at offset 6, ack after 3 cycles
      mem_txn(1'b0, 2'd1, 1'b0, 64'h0000_0000_0000_1006, 64'hBEEF, 64'h0, 3, 0, 5'd0,
              sc, res, ba, bw, bs);
      check("SH wstrb", 64'(bs), 64'hC0);
      check("SH wdata", bw, 64'hBEEF_0000_0000_0000);

      // Further aligned accesses, including a same-cycle ack
      mem_txn(1'b0, 2'd2, 1'b0, 64'h10C, 64'h1122_3344_5566_7788, 64'h0, 0, 0, 5'd0,
              sc, res, ba, bw, bs);
      check("SW wdata", bw, 64'h5566_7788_0000_0000);
      mem_txn(1'b0, 2'd0, 1'b0, 64'h5, 64'hAB, 64'h0, 1, 0, 5'd0, sc, res, ba, bw, bs);
      mem_txn(1'b1, 2'd3, 1'b0, 64'h4008, 64'h0, 64'h0123_4567_89AB_CDEF, 1, 0, 5'd12,
              sc, res, ba, bw, bs);
      check("LD result", res, 64'h0123_4567_89AB_CDEF);
      check("LD min stall cycles", 64'(sc), 64'd3);

      // Misaligned accesses: no request, trap flag only
      mis_cycle(1'b1, 2'd2, 64'h0000_0000_0000_2002);
      idle_cycle(64'h42, 5'd4, 1'b0);
      mis_cycle(1'b0, 2'd3, 64'h0000_0000_0000_2004);
      idle_cycle(64'h43, 5'd4, 1'b0);

      // Flush one cycle into WAIT, ack 3 cycles later, new load during DRAIN
      step();
      load_valid_i = 1'b1; store_valid_i = 1'b0; mem_size_i = 2'd3; mem_unsigned_i = 1'b0;
      alu_data_i = 64'h2000; rd_addr_i = 5'd9;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      flush_i = 1'b1;
      set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); e_rd = 5'd0;
      step();
      flush_i = 1'b0; load_valid_i = 1'b0; alu_data_i = 64'h77; rd_addr_i = 5'd0;
      set_exp(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); e_rd = 5'd0;
      step();
      load_valid_i = 1'b1; mem_size_i = 2'd2; mem_unsigned_i = 1'b1;
      alu_data_i = 64'h3004; rd_addr_i = 5'd11;
      set_exp(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0); e_rd = 5'd0;
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 64'h1111_1111_1111_1111;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      mem_ack_i = 1'b0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      mem_ack_i = 1'b1; mem_rdata_i = 64'hCAFE_BABE_8765_4321;
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      e_we = 1'b0; e_addr = 64'h3000;
      step();
      mem_ack_i = 1'b0; mem_rdata_i = '0;
      set_exp(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      e_rd = 5'd11; e_data = ld_model(2'd2, 1'b1, 64'h3004, 64'hCAFE_BABE_8765_4321);
      #2; check("post-drain LWU", mem_data_o, 64'h0000_0000_CAFE_BABE);
      idle_cycle(64'h88, 5'd2, 1'b0);

      // Load held in DONE by 2 cycles of downstream stall
      mem_txn(1'b1, 2'd1, 1'b0, 64'h102, 64'h0, 64'h0000_0000_8001_0000, 0, 2, 5'd13,
              sc, res, ba, bw, bs);
      check("LH held result", res, 64'hFFFF_FFFF_FFFF_8001);

      // Asynchronous reset in the middle of a store's WAIT
      step();
      load_valid_i = 1'b0; store_valid_i = 1'b1; mem_size_i = 2'd3;
      alu_data_i = 64'h6000; store_data_i = 64'h99; rd_addr_i = 5'd0;
      set_exp(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      step();
      set_exp(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      e_we = 1'b1; e_addr = 64'h6000; e_wdata = 64'h99; e_wstrb = 8'hFF;
      step();
      ck_on = 1'b0;
      rst = 1'b0;
      #1;
      check("midrst mem_req", 64'(mem_req_o), 64'h0);
      check("midrst mem_we", 64'(mem_we_o), 64'h0);
      check("midrst mem_addr", mem_addr_o, 64'h0);
      check("midrst mem_wdata", mem_wdata_o, 64'h0);
      check("midrst mem_wstrb", 64'(mem_wstrb_o), 64'h0);
      store_valid_i = 1'b0;
      step();
      rst = 1'b1;
      idle_cycle(64'hABCD, 5'd8, 1'b0);
      idle_cycle(64'hABCE, 5'd9, 1'b0);
      step();
      ck_on = 1'b0;

      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end

endmodule
`default_nettype wire
